// File: rtl/aes_pkg.sv
// Shared AES-128 constants, tables and GF(2^8) helpers for the CBC decryptor.
package aes_pkg;

  localparam int unsigned Nr = 10;

  typedef logic [127:0] block_t;
  typedef logic [31:0]  word_t;

  typedef enum logic [1:0] {StIdle, StKexp, StRound, StDone} dec_state_e;

  // rcon[1..10], stored zero-based.
  localparam logic [7:0] RconTab [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Entry x sits at bits [8*(255-x) +: 8], i.e. index {~x, 3'b000}.
  localparam logic [2047:0] Sbox = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] InvSbox = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return Sbox[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return InvSbox[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul2(input logic [7:0] b);
    return xtime(b);
  endfunction

  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic word_t sub_word(input word_t w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns.
module aes_inv_round
  import aes_pkg::*;
(
  input  block_t state_i,
  input  block_t round_key_i,
  input  logic   last_i,
  output block_t state_o
);

  logic [7:0] ark [16];

  function automatic word_t inv_mix_column(input word_t a);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] m2 [4];
    logic [7:0] m4 [4];
    logic [7:0] m8 [4];
    logic [7:0] x9 [4];
    logic [7:0] xb [4];
    logic [7:0] xd [4];
    logic [7:0] xe [4];
    a0 = a[31:24];
    a1 = a[23:16];
    a2 = a[15:8];
    a3 = a[7:0];
    m2 = '{gf_mul2(a0), gf_mul2(a1), gf_mul2(a2), gf_mul2(a3)};
    m4 = '{gf_mul2(m2[0]), gf_mul2(m2[1]), gf_mul2(m2[2]), gf_mul2(m2[3])};
    m8 = '{gf_mul2(m4[0]), gf_mul2(m4[1]), gf_mul2(m4[2]), gf_mul2(m4[3])};
    x9 = '{m8[0] ^ a0, m8[1] ^ a1, m8[2] ^ a2, m8[3] ^ a3};
    xb = '{m8[0] ^ m2[0] ^ a0, m8[1] ^ m2[1] ^ a1, m8[2] ^ m2[2] ^ a2, m8[3] ^ m2[3] ^ a3};
    xd = '{m8[0] ^ m4[0] ^ a0, m8[1] ^ m4[1] ^ a1, m8[2] ^ m4[2] ^ a2, m8[3] ^ m4[3] ^ a3};
    xe = '{m8[0] ^ m4[0] ^ m2[0], m8[1] ^ m4[1] ^ m2[1], m8[2] ^ m4[2] ^ m2[2],
           m8[3] ^ m4[3] ^ m2[3]};
    return {xe[0] ^ xb[1] ^ xd[2] ^ x9[3],
            x9[0] ^ xe[1] ^ xb[2] ^ xd[3],
            xd[0] ^ x9[1] ^ xe[2] ^ xb[3],
            xb[0] ^ xd[1] ^ x9[2] ^ xe[3]};
  endfunction

  // Byte b = row + 4*col; InvShiftRows moves row r right by r, so source col is (col - r) mod 4.
  always_comb begin
    for (int b = 0; b < 16; b++) begin
      ark[b] = inv_sbox(state_i[127 - 8 * ((b % 4) + 4 * (((b / 4) + 4 - (b % 4)) % 4)) -: 8])
               ^ round_key_i[127 - 8 * b -: 8];
    end
  end

  always_comb begin
    state_o = '0;
    for (int c = 0; c < 4; c++) begin
      if (last_i) begin
        state_o[127 - 32 * c -: 32] = {ark[4 * c], ark[4 * c + 1], ark[4 * c + 2], ark[4 * c + 3]};
      end else begin
        state_o[127 - 32 * c -: 32] =
            inv_mix_column({ark[4 * c], ark[4 * c + 1], ark[4 * c + 2], ark[4 * c + 3]});
      end
    end
  end

endmodule

// File: rtl/cbc_dec_core.sv
// Iterative AES-128 CBC block decryptor: forward key expansion, then ten inverse rounds.
module cbc_dec_core
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ciphertext,
  input  logic [127:0] key,
  input  logic [127:0] iv,
  output logic         out_valid,
  output logic [127:0] plaintext
);

  localparam logic [3:0] LastStep = 4'(Nr - 1);

  dec_state_e st_q, st_d;
  logic [3:0] cnt_q, cnt_d;
  block_t     rk_q, rk_d;
  block_t     blk_q, blk_d;
  block_t     iv_q, iv_d;
  block_t     pt_q, pt_d;
  block_t     rk_fwd, rk_inv, round_out;
  logic [7:0] rc;

  function automatic block_t key_step_fwd(input block_t rk, input logic [7:0] rcon);
    word_t w0, w1, w2, w3;
    w0 = rk[127:96] ^ sub_word(rot_word(rk[31:0])) ^ {rcon, 24'h0};
    w1 = rk[95:64] ^ w0;
    w2 = rk[63:32] ^ w1;
    w3 = rk[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic block_t key_step_inv(input block_t rk, input logic [7:0] rcon);
    word_t w0, w1, w2, w3;
    w3 = rk[31:0] ^ rk[63:32];
    w2 = rk[63:32] ^ rk[95:64];
    w1 = rk[95:64] ^ rk[127:96];
    w0 = rk[127:96] ^ sub_word(rot_word(w3)) ^ {rcon, 24'h0};
    return {w0, w1, w2, w3};
  endfunction

  // cnt_q is the expansion step in KEXP and the round number r in ROUND; both use rcon[cnt+1].
  assign rc     = RconTab[cnt_q];
  assign rk_fwd = key_step_fwd(rk_q, rc);
  assign rk_inv = key_step_inv(rk_q, rc);

  aes_inv_round u_inv_round (
    .state_i    (blk_q),
    .round_key_i(rk_inv),
    .last_i     (cnt_q == 4'd0),
    .state_o    (round_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= StIdle;
    end else begin
      st_q <= st_d;
    end
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      StIdle:  if (in_valid) st_d = StKexp;
      StKexp:  if (cnt_q == LastStep) st_d = StRound;
      StRound: if (cnt_q == 4'd0) st_d = StDone;
      StDone:  st_d = StIdle;
      default: st_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (st_q == StIdle);
    out_valid = (st_q == StDone);
    plaintext = pt_q;
  end

  always_comb begin
    cnt_d = cnt_q;
    rk_d  = rk_q;
    blk_d = blk_q;
    iv_d  = iv_q;
    pt_d  = pt_q;
    case (st_q)
      StIdle: begin
        if (in_valid) begin
          rk_d  = key;
          blk_d = ciphertext;
          iv_d  = iv;
          cnt_d = 4'd0;
        end
      end
      StKexp: begin
        rk_d = rk_fwd;
        if (cnt_q == LastStep) begin
          blk_d = blk_q ^ rk_fwd;
          cnt_d = LastStep;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StRound: begin
        rk_d  = rk_inv;
        blk_d = round_out;
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Unchain on the final round edge so plaintext is already valid while out_valid is high.
          pt_d = round_out ^ iv_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      rk_q  <= '0;
      blk_q <= '0;
      iv_q  <= '0;
      pt_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      rk_q  <= rk_d;
      blk_q <= blk_d;
      iv_q  <= iv_d;
      pt_q  <= pt_d;
    end
  end

endmodule

// File: tb/tb_cbc_dec_core.sv
// Directed-vector bench for cbc_dec_core using FIPS-197 and SP800-38A CBC vectors.
module tb_cbc_dec_core;

  localparam logic [127:0] Key   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CtB   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PtB   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] Iv0   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] Ct1   = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] Pt1   = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] Ct2   = 128'h5086cb9b507219ee95db113a917678b2;
  localparam logic [127:0] Pt2   = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] Junk  = 128'hdeadbeef0123456789abcdeffedcba98;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] ciphertext;
  logic [127:0] key;
  logic [127:0] iv;
  logic         out_valid;
  logic [127:0] plaintext;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cbc_dec_core u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ciphertext(ciphertext),
    .key       (key),
    .iv        (iv),
    .out_valid (out_valid),
    .plaintext (plaintext)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Present one block at a negedge; returns just after the accepting posedge (cycle 0).
  task automatic issue(input string tag, input logic [127:0] c, input logic [127:0] k,
                       input logic [127:0] v);
    @(negedge clk);
    check_eq({tag, "_ready_before"}, in_ready, 1'b1);
    ciphertext = c;
    key        = k;
    iv         = v;
    in_valid   = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Observe cycles cyc0+1 .. cyc0+n at the negedge, tracking the first out_valid pulse.
  task automatic watch(input int n, input int cyc0, inout int first, inout int pulses,
                       inout logic [127:0] pt);
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (out_valid) begin
        pulses++;
        if (first == 0) begin
          first = cyc0 + i;
          pt    = plaintext;
        end
      end
    end
  endtask

  task automatic run_block(input string tag, input logic [127:0] c, input logic [127:0] k,
                           input logic [127:0] v, input logic [127:0] exp, input logic scramble);
    int           first;
    int           pulses;
    logic [127:0] pt;
    first  = 0;
    pulses = 0;
    pt     = '0;
    issue(tag, c, k, v);
    if (scramble) begin
      ciphertext = Junk;
      key        = ~Junk;
      iv         = Junk ^ 128'h1;
    end
    watch(25, 0, first, pulses, pt);
    check_eq({tag, "_latency"}, first, 21);
    check_eq({tag, "_plaintext"}, pt, exp);
    check_eq({tag, "_pulses"}, pulses, 1);
    check_eq({tag, "_ready_after"}, in_ready, 1'b1);
  endtask

  initial begin
    int           first;
    int           pulses;
    logic [127:0] pt;

    rst        = 1'b1;
    in_valid   = 1'b0;
    ciphertext = '0;
    key        = '0;
    iv         = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_eq("reset_plaintext", plaintext, '0);
    check_eq("reset_out_valid", out_valid, 1'b0);
    check_eq("reset_in_ready", in_ready, 1'b1);

    run_block("appb", CtB, Key, '0, PtB, 1'b0);
    run_block("cbc1", Ct1, Key, Iv0, Pt1, 1'b0);

    // Back-to-back with in_valid held high: second accept must wait for in_ready.
    @(negedge clk);
    ciphertext = Ct1;
    key        = Key;
    iv         = Iv0;
    in_valid   = 1'b1;
    @(posedge clk);
    #1;
    ciphertext = Ct2;
    iv         = Ct1;
    first      = 0;
    pulses     = 0;
    pt         = '0;
    watch(20, 0, first, pulses, pt);
    check_eq("b2b_no_early_out", pulses, 0);
    @(negedge clk);
    check_eq("b2b_out1_valid", out_valid, 1'b1);
    check_eq("b2b_out1_plaintext", plaintext, Pt1);
    check_eq("b2b_busy_in_done", in_ready, 1'b0);
    @(negedge clk);
    check_eq("b2b_ready_c22", in_ready, 1'b1);
    check_eq("b2b_out1_width", out_valid, 1'b0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    first  = 0;
    pulses = 0;
    watch(25, 22, first, pulses, pt);
    check_eq("b2b_out2_cycle", first, 43);
    check_eq("b2b_out2_plaintext", pt, Pt2);
    check_eq("b2b_out2_pulses", pulses, 1);

    // in_valid pulsed with other data while busy must be ignored.
    first  = 0;
    pulses = 0;
    pt     = '0;
    issue("busy", CtB, Key, '0);
    watch(4, 0, first, pulses, pt);
    ciphertext = Junk;
    key        = ~Junk;
    iv         = Junk;
    in_valid   = 1'b1;
    watch(1, 4, first, pulses, pt);
    check_eq("busy_not_ready", in_ready, 1'b0);
    in_valid = 1'b0;
    watch(30, 5, first, pulses, pt);
    check_eq("busy_latency", first, 21);
    check_eq("busy_plaintext", pt, PtB);
    check_eq("busy_pulses", pulses, 1);

    // Reset sampled at the cycle-12 edge aborts the block.
    first  = 0;
    pulses = 0;
    issue("abort", Ct1, Key, Iv0);
    watch(11, 0, first, pulses, pt);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("abort_plaintext", plaintext, '0);
    check_eq("abort_in_ready", in_ready, 1'b1);
    check_eq("abort_out_valid", out_valid, 1'b0);
    watch(30, 12, first, pulses, pt);
    check_eq("abort_no_pulse", pulses, 0);
    run_block("fresh", CtB, Key, '0, PtB, 1'b0);

    run_block("scramble", Ct2, Key, Ct1, Pt2, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "bench did not complete");
  end

endmodule

// File: doc/cbc_dec_core.md
Name: cbc_dec_core

Overview:
- AES-128 CBC-mode block decryptor: plaintext = AES128_Decrypt(key, ciphertext) XOR iv.
- Iterative, one inverse round per clock. Sits between the ciphertext stream source and the plaintext sink.
- Chaining is done by the caller: iv for block n is ciphertext block n-1; the first block uses the session IV.
- Key, iv and ciphertext are all supplied per block.

Parameters:
- none (AES-128 only; Nr = 10 fixed).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  request to decrypt one block
- in_ready  out  1  high when idle and able to accept
- ciphertext  in  128  ciphertext block; bit 127..120 = AES state byte 0 (FIPS-197 byte order)
- key  in  128  cipher key, same byte order
- iv  in  128  chaining value XORed into the decrypted block
- out_valid  out  1  one-cycle pulse: plaintext is new
- plaintext  out  128  decrypted block, registered

Behaviour:
- Reset (rst=1 at posedge):
  - state returns to IDLE; plaintext=0, out_valid=0, in_ready=1 on the following cycle.
  - Reset during an operation aborts it; no out_valid is produced for that block.
- Accept: transfer occurs when in_valid && in_ready at a posedge (cycle 0). ciphertext, key and iv are captured into internal registers; inputs are don't-care afterwards.
- States:
  - IDLE: in_ready=1.
  - KEXP: 10 cycles; forward key expansion from the captured key to round key 10 (rcon 01,02,04,08,10,20,40,80,1b,36). On the last KEXP cycle the state register is loaded with ciphertext XOR rk10.
  - ROUND: 10 cycles, r = 9 down to 0. Each cycle applies InvShiftRows, InvSubBytes, AddRoundKey(rk[r]), then InvMixColumns except when r=0.
    - rk[r] is derived from rk[r+1] by the inverse key schedule:
      - w3' = w3^w2, w2' = w2^w1, w1' = w1^w0
      - w0' = w0 ^ SubWord(RotWord(w3')) ^ rcon[r+1]
    - No 11-entry key RAM.
  - DONE: 1 cycle; plaintext <= state XOR captured iv; out_valid=1; then IDLE.
- Latency: accept at cycle 0 -> out_valid high in cycle 21. Throughput is 1 block per 22 cycles (in_ready returns high the cycle after DONE).
- in_ready=0 in KEXP/ROUND/DONE; in_valid is ignored while busy (no queuing).
- plaintext holds its value until the next DONE or reset; out_valid is exactly one cycle wide.
- Key change between blocks is allowed, since each accept re-expands from the key presented at that accept.
- All arithmetic is GF(2^8) with polynomial 0x11b. InvMixColumns matrix: [0e 0b 0d 09] rotated per row.

Decomposition:
- Shared package aes_pkg holds:
  - Nr=10, the rcon table, the forward S-box (for key schedule) and inverse S-box as constant functions/arrays
  - gf_mul2 / xtime helpers
  - a 128-bit block typedef
- One sub-module, aes_inv_round: combinational, (state, round_key, last) -> next state. It contains 16 inverse S-box lookups, InvShiftRows and InvMixColumns.
- Key schedule and FSM live in cbc_dec_core.

Test Plan:
- FIPS-197 App B: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32, iv 0 -> plaintext 3243f6a8885a308d313198a2e0370734, out_valid exactly at cycle 21.
- SP800-38A CBC block 1: same key, iv 000102030405060708090a0b0c0d0e0f, ct 7649abac8119b246cee98e9b12e9197d -> plaintext 6bc1bee22e409f96e93d7e117393172a.
- Chaining, block 2: iv 7649abac8119b246cee98e9b12e9197d, ct 5086cb9b507219ee95db113a917678b2 -> plaintext ae2d8a571e03ac9c9eb76fac45af8e51. Issue back-to-back with in_valid held high; check the second accept occurs only when in_ready=1.
- Busy ignore: pulse in_valid with different data at cycle 5 -> first result unchanged, no extra out_valid.
- Reset mid-operation: assert rst at cycle 12 -> no out_valid, plaintext=0, in_ready=1 next cycle; then a fresh App B vector decrypts correctly.
- Input change after accept: alter ciphertext/key/iv at cycle 1 -> result still matches the values captured at accept.
